ceespu_mc_sequencer: RTL and testbench
======================================

Name: ceespu_mc_sequencer

Overview:
Execute-stage controller on the consuming end of the ALU multi-cycle handshake (multiCycle / dataReady).
- Detects a multi-cycle op entering execute and stalls the front of the pipeline until the ALU signals completion.
- Captures the result and destination register, then issues a one-cycle writeback strobe.
- Supervises the op with a watchdog timeout and honours pipeline flushes.

Parameters:
TIMEOUT_CYCLES, 8, max cycles in WAIT before abort (legal range 2..15)
CNT_W, 4, width of WAIT-cycle counter; must hold TIMEOUT_CYCLES

Ports:
I_clk  in  1  clock, all state on rising edge
I_rst  in  1  synchronous active-high reset
I_valid  in  1  execute stage holds a valid instruction
I_multiCycle  in  1  ALU: current op is multi-cycle (combinational)
I_dataReady  in  1  ALU: multi-cycle result valid this cycle
I_aluResult  in  32  ALU dataResult
I_rdAddr  in  5  destination register of instruction in execute
I_flush  in  1  pipeline flush (branch/exception)
O_stall  out  1  hold fetch/decode/execute pipeline registers
O_busy  out  1  sequencer not IDLE
O_wbValid  out  1  one-cycle strobe: O_wbData/O_wbAddr valid
O_wbData  out  32  captured multi-cycle result
O_wbAddr  out  5  captured destination register
O_timeout  out  1  one-cycle pulse: op aborted by watchdog

Behaviour:
- Reset (I_rst=1 at clock edge), regardless of state:
  - state=IDLE, counter=0.
  - O_wbValid=0, O_wbData=0, O_wbAddr=0, O_timeout=0.
  - Reset mid-operation discards the op; no strobe is issued.
- States: IDLE, WAIT, DONE. Encoding is free.
- O_stall (combinational):
  - =1 in IDLE when I_valid & I_multiCycle & ~I_flush.
  - =1 in WAIT.
  - =0 in DONE and otherwise.
- O_busy = (state != IDLE), registered-state derived.
- IDLE:
  - I_valid & I_multiCycle & ~I_flush -> WAIT.
  - Latch I_rdAddr into the internal rd register.
  - Clear counter.
  - Any other input combination: stay in IDLE; single-cycle ops pass untouched.
- WAIT, in priority order:
  1. I_flush -> IDLE. No strobe. Flush wins over a simultaneous I_dataReady.
  2. I_dataReady -> DONE. O_wbData<=I_aluResult, O_wbAddr<=latched rd, O_wbValid<=1.
  3. counter==TIMEOUT_CYCLES-1 -> IDLE, O_timeout<=1.
  4. Otherwise counter<=counter+1 and stay in WAIT.
- DONE:
  - Stall released; the multi-cycle instruction leaves execute at the end of this cycle.
  - I_multiCycle is ignored (no re-trigger) and the state always returns to IDLE.
  - O_wbValid is high only in this cycle.
  - O_wbData/O_wbAddr hold until the next capture.
- O_wbValid and O_timeout are registered single-cycle pulses, cleared the following cycle. They are never high simultaneously.
- I_valid is ignored outside IDLE; the pipeline is stalled, so its value is don't-care.
- Latency, with the issue cycle T being the first IDLE cycle with a trigger:
  - Stall high in cycles T..R, where R is the cycle with I_dataReady=1.
  - DONE and O_wbValid at R+1.
  - Nominal ALU: R=T+2, giving stall for 3 cycles and the strobe at T+3.
- Back-to-back multi-cycle ops: the second op is seen in IDLE at DONE+1 and re-triggers normally. There is no bubble beyond the DONE cycle.

Test Plan:
1. Reset then mul trigger at T, I_rdAddr=5, I_dataReady at T+2 with I_aluResult=32'h0000_0F00 -> O_stall=1 for T..T+2, 0 at T+3; O_wbValid=1 only at T+3 with O_wbData=32'h0000_0F00, O_wbAddr=5.
2. Single-cycle op (I_valid=1, I_multiCycle=0) for 10 cycles -> O_stall=0, O_busy=0, O_wbValid=0 throughout.
3. Trigger, I_dataReady held 0, TIMEOUT_CYCLES=8 -> O_timeout pulse exactly one cycle after the 8th WAIT cycle, state IDLE, O_wbValid never asserted, O_wbData unchanged.
4. Trigger, then I_flush=1 and I_dataReady=1 in the same WAIT cycle -> next cycle IDLE, O_wbValid=0, O_stall=0; repeat with I_flush=1 in the trigger cycle -> no transition, O_stall=0.
5. Two consecutive mul ops (rd=3, result 7; rd=4, result 9) -> two O_wbValid strobes exactly 4 cycles apart carrying (7,3) then (9,4); no extra strobe from the DONE cycle.
6. I_rst asserted in WAIT -> next cycle all outputs 0, state IDLE; the subsequent I_dataReady pulse produces no strobe.

Source files
------------

// File: rtl/ceespu_mc_sequencer_if.sv
// Execute-stage side of the ALU multi-cycle handshake plus the writeback strobe.
// The slave modport is the sequencer; the master modport is the pipeline/ALU side.
interface ceespu_mc_sequencer_if;
  logic        I_valid;
  logic        I_multiCycle;
  logic        I_dataReady;
  logic [31:0] I_aluResult;
  logic [4:0]  I_rdAddr;
  logic        I_flush;
  logic        O_stall;
  logic        O_busy;
  logic        O_wbValid;
  logic [31:0] O_wbData;
  logic [4:0]  O_wbAddr;
  logic        O_timeout;

  modport slave (
    input  I_valid, I_multiCycle, I_dataReady, I_aluResult, I_rdAddr, I_flush,
    output O_stall, O_busy, O_wbValid, O_wbData, O_wbAddr, O_timeout
  );

  modport master (
    output I_valid, I_multiCycle, I_dataReady, I_aluResult, I_rdAddr, I_flush,
    input  O_stall, O_busy, O_wbValid, O_wbData, O_wbAddr, O_timeout
  );
endinterface

// File: rtl/ceespu_mc_sequencer.sv
// Stalls the front of the pipeline while a multi-cycle ALU op runs, captures its
// result for a one-cycle writeback strobe, and aborts it on flush or watchdog expiry.
module ceespu_mc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned CNT_W          = 4
) (
  input logic                  I_clk,
  input logic                  I_rst,
  ceespu_mc_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd;
  logic             r_wbValid;
  logic [31:0]      r_wbData;
  logic [4:0]       r_wbAddr;
  logic             r_timeout;
  logic             w_trigger;

  assign w_trigger = bus.I_valid & bus.I_multiCycle & ~bus.I_flush;

  // Stall asserts combinationally in the issue cycle so the op is held in execute.
  assign bus.O_stall   = ((r_state == S_IDLE) & w_trigger) | (r_state == S_WAIT);
  assign bus.O_busy    = (r_state != S_IDLE);
  assign bus.O_wbValid = r_wbValid;
  assign bus.O_wbData  = r_wbData;
  assign bus.O_wbAddr  = r_wbAddr;
  assign bus.O_timeout = r_timeout;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_wbValid <= 1'b0;
      r_wbData  <= '0;
      r_wbAddr  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wbValid <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state <= S_WAIT;
            r_rd    <= bus.I_rdAddr;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          // Flush outranks a same-cycle completion; the result is dropped.
          if (bus.I_flush) begin
            r_state <= S_IDLE;
          end else if (bus.I_dataReady) begin
            r_state   <= S_DONE;
            r_wbData  <= bus.I_aluResult;
            r_wbAddr  <= r_rd;
            r_wbValid <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ceespu_mc_sequencer.sv
// Directed and randomized checks of the multi-cycle sequencer against a
// transaction-level model of stall, strobe, flush and watchdog timing.
module tb_ceespu_mc_sequencer;

  localparam int unsigned TO = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic        pend_to;
  logic [31:0] exp_data;
  logic [4:0]  exp_addr;

  ceespu_mc_sequencer_if bus ();

  ceespu_mc_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs of this cycle, advance past the edge.
  task automatic cyc(input logic v, input logic mc, input logic dr, input logic fl,
                     input logic [31:0] res, input logic [4:0] rd,
                     input logic e_stall, input logic e_busy, input logic e_wbv);
    bus.I_valid      = v;
    bus.I_multiCycle = mc;
    bus.I_dataReady  = dr;
    bus.I_flush      = fl;
    bus.I_aluResult  = res;
    bus.I_rdAddr     = rd;
    #1;
    chk("stall",   32'(bus.O_stall),   32'(e_stall));
    chk("busy",    32'(bus.O_busy),    32'(e_busy));
    chk("wbValid", 32'(bus.O_wbValid), 32'(e_wbv));
    chk("timeout", 32'(bus.O_timeout), 32'(pend_to));
    chk("wbData",  bus.O_wbData,       exp_data);
    chk("wbAddr",  32'(bus.O_wbAddr),  32'(exp_addr));
    pend_to = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with random inputs that never form a trigger.
  task automatic idle_cyc();
    logic v, mc, fl;
    v  = 1'($urandom);
    mc = 1'($urandom);
    fl = 1'($urandom);
    if (v && mc) fl = 1'b1;
    cyc(v, mc, 1'($urandom), fl, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  // One op issued at cycle 0. After-issue cycle k in 1..TO: flush at k==f ends it,
  // else ready at k==d completes it (strobe next cycle), else TO waits end in timeout.
  task automatic run_op(input logic [4:0] rd, input logic [31:0] res,
                        input int unsigned d, input int unsigned f);
    int unsigned kend;
    bit          ok;
    kend = 0;
    ok   = 1'b0;
    for (int unsigned k = 1; k <= TO; k++)
      if (kend == 0 && (k == f || k == d)) begin
        kend = k;
        ok   = (k != f);
      end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, $urandom, rd, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 1; k <= TO; k++) begin
      cyc(1'($urandom), 1'($urandom), k == d, k == f, (k == d) ? res : $urandom,
          5'($urandom), 1'b1, 1'b1, 1'b0);
      if (k == kend) break;
    end
    if (kend == 0) begin
      pend_to = 1'b1;
    end else if (ok) begin
      exp_data = res;
      exp_addr = rd;
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
          5'($urandom), 1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pend_to  = 1'b0;
    exp_data = '0;
    exp_addr = '0;
    rst = 1'b1;
    bus.I_valid = 1'b0; bus.I_multiCycle = 1'b0; bus.I_dataReady = 1'b0;
    bus.I_flush = 1'b0; bus.I_aluResult = '0;    bus.I_rdAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Nominal mul: ready two cycles after issue.
    run_op(5'd5, 32'h0000_0F00, 2, 0);
    idle_cyc();

    // Single-cycle ops pass untouched.
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b0);

    // Watchdog expiry, result registers unchanged.
    run_op(5'd9, 32'hDEAD_BEEF, 99, 0);
    idle_cyc();

    // Flush together with ready, then flush in the issue cycle.
    run_op(5'd11, 32'h1234_5678, 2, 2);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, $urandom, 5'd12, 1'b0, 1'b0, 1'b0);
    idle_cyc();

    // Back-to-back ops: strobes 4 cycles apart.
    run_op(5'd3, 32'd7, 2, 0);
    run_op(5'd4, 32'd9, 2, 0);
    idle_cyc();

    // Reset while waiting discards the op.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, $urandom, 5'd6, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, $urandom, 5'd1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 5'd1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    exp_data = '0;
    exp_addr = '0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Randomized ops: mixed completion delays, flushes, timeouts and gaps.
    for (int i = 0; i < 60; i++) begin
      int unsigned d, f;
      d = $urandom_range(1, 11);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
      run_op(5'($urandom), $urandom, d, f);
      repeat ($urandom_range(0, 2)) idle_cyc();
    end
    idle_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
